// File: rtl/cgra_cfg_pkg.sv
// Shared types and sizing helpers for the CGRA serial configuration loader.
package cgra_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DRAIN,
        DONE
    } cfg_state_t;

    localparam int WORD_W = 32;

    // Number of stream words needed to cover a chain of chain_len bits.
    function automatic int cfg_nwords(input int chain_len, input int word_w = WORD_W);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/cfg_shift_word.sv
// One word register that serialises a loaded word MSB-first while collecting
// the returned chain bits at the LSB, so it ends up holding the readback word.
module cfg_shift_word #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic [WIDTH-1:0] shift_next
);

    logic [WIDTH-1:0] q;

    assign ser_out    = q[WIDTH-1];
    assign shift_next = {q[WIDTH-2:0], ser_in};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= shift_next;
        end
    end

endmodule

// File: rtl/cgra_config_loader.sv
// Streams configuration words bit-serially into the CGRA config chain and
// returns the displaced chain contents as a readback word stream.
module cgra_config_loader #(
    parameter int CHAIN_LEN = 184,
    parameter int WORD_W    = cgra_cfg_pkg::WORD_W
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              cfg_bit,
    output logic              cfg_shift_en,
    input  logic              cfg_return,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready
);

    import cgra_cfg_pkg::*;

    localparam int NWORDS = cfg_nwords(CHAIN_LEN, WORD_W);
    localparam int BCNT_W = $clog2(WORD_W);
    localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NWORDS - 1);

    cfg_state_t        state;
    cfg_state_t        state_next;
    logic [BCNT_W-1:0] bit_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic              rb_free;
    logic              rb_fire;
    logic              s_fire;
    logic              last_bit;
    logic              sr_msb;
    logic [WORD_W-1:0] sr_next;

    // The readback slot must be free before a new word starts shifting, so a
    // stalled consumer holds the loader in LOAD rather than breaking a word.
    assign rb_free  = !rb_valid || rb_ready;
    assign rb_fire  = rb_valid && rb_ready;
    assign s_fire   = s_valid && s_ready;
    assign last_bit = (bit_cnt == BIT_LAST);
    assign cfg_bit  = cfg_shift_en && sr_msb;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        busy         = 1'b1;
        done         = 1'b0;
        s_ready      = 1'b0;
        cfg_shift_en = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = LOAD;
            end
            LOAD: begin
                s_ready = rb_free;
                if (s_valid && rb_free) state_next = SHIFT;
            end
            SHIFT: begin
                cfg_shift_en = 1'b1;
                if (last_bit) state_next = (word_cnt == WORD_LAST) ? DRAIN : LOAD;
            end
            DRAIN: begin
                if (rb_fire) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Config_Clock) begin
        if (Config_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Config_Clock) begin
        if (Config_Reset) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (state == IDLE && start) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (cfg_shift_en) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            if (last_bit) word_cnt <= word_cnt + 1'b1;
        end
    end

    // The final shift's returned bit is folded in directly from shift_next.
    always_ff @(posedge Config_Clock) begin
        if (Config_Reset) begin
            rb_valid <= 1'b0;
            rb_data  <= '0;
        end else begin
            if (rb_fire) rb_valid <= 1'b0;
            if (cfg_shift_en && last_bit) begin
                rb_valid <= 1'b1;
                rb_data  <= sr_next;
            end
        end
    end

    cfg_shift_word #(
        .WIDTH(WORD_W)
    ) u_shift_word (
        .clk       (Config_Clock),
        .rst       (Config_Reset),
        .load      (s_fire),
        .shift     (cfg_shift_en),
        .load_data (s_data),
        .ser_in    (cfg_return),
        .ser_out   (sr_msb),
        .shift_next(sr_next)
    );

endmodule
